// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-addressed data memory / load-store unit.
//   size_e     : access size encoding carried on req_size
//   state_e    : sequencing states of the LSU
//   size_bytes : number of bytes touched by an access of a given size
//   extend     : sign/zero extension of right-justified load data to 64 bits
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_D
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    BEAT1,
    BEAT2
  } state_e;

  function automatic logic [3:0] size_bytes(size_e size);
    case (size)
      SZ_B:    return 4'd1;
      SZ_H:    return 4'd2;
      SZ_W:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [63:0] extend(logic [63:0] data, size_e size, logic sgn);
    case (size)
      SZ_B:    return {{56{sgn & data[7]}}, data[7:0]};
      SZ_H:    return {{48{sgn & data[15]}}, data[15:0]};
      SZ_W:    return {{32{sgn & data[31]}}, data[31:0]};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response bundle between the datapath and the data-memory LSU.
//   req_valid/req_ready : request handshake, transfer when both high at a rising edge
//   req_we/req_size/req_signed/req_addr/req_wdata : request attributes
//   rsp_valid/rsp_rdata/rsp_err : single-cycle response, no backpressure
// Modports: master (datapath side), slave (LSU side).
interface dmem_lsu_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_byte_ram.sv
// Single-port synchronous RAM with per-byte write enables.
//   clk   : clock, rising edge
//   addr  : word address
//   we    : one write enable per byte lane
//   wdata : write data, lane k on bits [8k+7:8k]
//   rdata : registered read data; returns the pre-write contents on a write cycle
// Contents are not reset.
module dmem_byte_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 65536
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W/8-1:0]      we,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  localparam int unsigned Nb = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    rdata <= mem[addr];
    for (int k = 0; k < int'(Nb); k++) begin
      if (we[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
    end
  end

endmodule

// File: rtl/dmem_lsu.sv
// Byte-addressed data memory with load/store unit (little-endian).
// Byte/half/word(/dword) loads and stores, byte-lane write enables, sign/zero-extended
// loads, valid/ready request port and a one-cycle response pulse.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous reset, active-low
//   bus   : dmem_lsu_if.slave request/response bundle
// Build option DMEM_MISALIGN_SPLIT_EN: when defined, word-crossing accesses run as two RAM
// beats; when undefined, any access not aligned to its size is rejected with rsp_err.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 65536
) (
  input logic       clk,
  input logic       rst_n,
  dmem_lsu_if.slave bus
);

  localparam int unsigned Nb    = DATA_W / 8;
  localparam int unsigned OffW  = $clog2(Nb);
  localparam int unsigned WordW = $clog2(DEPTH);
  // First byte address past the end of the RAM; one extra bit so no access wraps.
  localparam logic [ADDR_W:0] LimitBytes = (ADDR_W + 1)'(DEPTH) << OffW;

  // Request decode (valid only while IDLE)
  size_e             size;
  logic [3:0]        sb;
  logic [3:0]        sb_m1;
  logic [OffW-1:0]   off;
  logic [WordW-1:0]  word;
  logic [ADDR_W:0]   end_addr;
  logic              size_err;
  logic              range_err;
  logic              req_err;
  logic              req_split;
  logic [2*Nb-1:0]   lane_full;
  logic [DATA_W-1:0] wdata_rot;

  assign size      = size_e'(bus.req_size);
  assign sb        = size_bytes(size);
  assign sb_m1     = sb - 4'd1;
  assign off       = bus.req_addr[OffW-1:0];
  assign word      = bus.req_addr[OffW +: WordW];
  assign end_addr  = {1'b0, bus.req_addr} + {{(ADDR_W-3){1'b0}}, sb_m1};
  assign size_err  = (DATA_W == 32) && (size == SZ_D);
  assign range_err = end_addr >= LimitBytes;

`ifdef DMEM_MISALIGN_SPLIT_EN
  logic [4:0] off_end;
  assign off_end   = 5'(off) + 5'(sb);
  assign req_err   = size_err | range_err;
  assign req_split = !req_err && (off_end > 5'(Nb));
`else
  logic align_err;
  assign align_err = |(bus.req_addr[2:0] & sb_m1[2:0]);
  assign req_err   = size_err | range_err | align_err;
  assign req_split = 1'b0;
`endif

  // Lane enables over two adjacent words (low half = beat 1, high half = beat 2) and
  // store data rotated so byte k lands on lane (addr+k)%Nb; the same rotated word serves
  // both beats because each beat only enables its own lanes.
  always_comb begin
    lane_full = '0;
    wdata_rot = '0;
    for (int k = 0; k < int'(Nb); k++) begin
      if (k < int'(sb)) lane_full[k + int'(off)] = 1'b1;
      wdata_rot[8*((k + int'(off)) % int'(Nb)) +: 8] = bus.req_wdata[8*k +: 8];
    end
  end

  // Latched request and datapath state
  state_e            state_q, state_d;
  logic              we_q;
  logic              signed_q;
  logic              err_q;
  logic              split_q;
  size_e             size_q;
  logic [OffW-1:0]   off_q;
  logic [WordW-1:0]  word_q;
  logic [Nb-1:0]     mask2_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] hold_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  // RAM port and FSM outputs
  logic [WordW-1:0]  ram_addr;
  logic [Nb-1:0]     ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_q;
  logic              req_ready;
  logic              rsp_fire;
  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] rsp_fmt;

  dmem_byte_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .addr (ram_addr),
    .we   (ram_we),
    .wdata(ram_wdata),
    .rdata(ram_q)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.req_valid) state_d = BEAT1;
      BEAT1:   state_d = split_q ? BEAT2 : IDLE;
      BEAT2:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. BEAT1 only reads word+1 so a load has it by E2; the beat-2 store
  // lanes are applied in BEAT2, so a reset during BEAT2 leaves word+1 untouched.
  always_comb begin
    req_ready = 1'b0;
    rsp_fire  = 1'b0;
    ram_addr  = word_q + WordW'(1);
    ram_we    = '0;
    ram_wdata = wdata_q;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        ram_addr  = word;
        ram_wdata = wdata_rot;
        if (bus.req_valid && bus.req_we && !req_err) ram_we = lane_full[Nb-1:0];
      end
      BEAT1: rsp_fire = !split_q;
      BEAT2: begin
        rsp_fire = 1'b1;
        if (we_q) ram_we = mask2_q;
      end
      default: ;
    endcase
  end

  // Load formatting: shift the addressed bytes down to lane 0, taking lanes past the
  // word end from the following word (only reached on a split access).
  always_comb begin
    lo     = (state_q == BEAT2) ? hold_q : ram_q;
    merged = '0;
    for (int k = 0; k < int'(Nb); k++) begin
      if (k + int'(off_q) < int'(Nb)) begin
        merged[8*k +: 8] = lo[8*(k + int'(off_q)) +: 8];
      end else begin
        merged[8*k +: 8] = ram_q[8*(k + int'(off_q) - int'(Nb)) +: 8];
      end
    end
  end

  assign rsp_fmt = DATA_W'(extend(64'(merged), size_q, signed_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      signed_q    <= 1'b0;
      err_q       <= 1'b0;
      split_q     <= 1'b0;
      size_q      <= SZ_B;
      off_q       <= '0;
      word_q      <= '0;
      mask2_q     <= '0;
      wdata_q     <= '0;
      hold_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      if (state_q == IDLE && bus.req_valid) begin
        we_q     <= bus.req_we;
        signed_q <= bus.req_signed;
        err_q    <= req_err;
        split_q  <= req_split;
        size_q   <= size;
        off_q    <= off;
        word_q   <= word;
        mask2_q  <= lane_full[2*Nb-1:Nb];
        wdata_q  <= wdata_rot;
      end
      if (state_q == BEAT1) hold_q <= ram_q;
      rsp_valid_q <= rsp_fire;
      if (rsp_fire) begin
        rsp_err_q   <= err_q;
        rsp_rdata_q <= (we_q || err_q) ? '0 : rsp_fmt;
      end
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
